// File: rtl/wave_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : wave_gen_if
// Description : Control and sample bus between the waveform generator and
//               its controller / downstream mixer stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface wave_gen_if #(
    parameter int BITLEN = 8
);
    logic              en;
    logic              step;
    logic [1:0]        wave_sel;
    logic [1:0]        atten;
    logic [BITLEN-1:0] sample;
    logic              sample_valid;
    logic              busy;
    logic [BITLEN-1:0] phase_out;

    modport master (
        output en,
        output step,
        output wave_sel,
        output atten,
        input  sample,
        input  sample_valid,
        input  busy,
        input  phase_out
    );

    modport slave (
        input  en,
        input  step,
        input  wave_sel,
        input  atten,
        output sample,
        output sample_valid,
        output busy,
        output phase_out
    );
endinterface
`default_nettype wire

// File: rtl/wave_gen.sv
`default_nettype none
// ============================================================================
// Module      : wave_gen
// Description : Strobe-driven phase accumulator producing square, sawtooth,
//               triangle or silence samples with wrap-aligned reconfiguration.
// Revision    : 1.0 - initial release
// ============================================================================
module wave_gen #(
    parameter int BITLEN = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    wave_gen_if.slave  bus
);

    localparam logic [BITLEN-1:0] MAX_VAL  = '1;
    localparam logic [BITLEN-1:0] MID_VAL  = {1'b1, {(BITLEN-1){1'b0}}};
    localparam logic [BITLEN-1:0] ZERO_VAL = '0;
    localparam logic [BITLEN-1:0] ONE_VAL  = {{(BITLEN-1){1'b0}}, 1'b1};

    localparam logic [1:0] WAVE_SQUARE = 2'b00;
    localparam logic [1:0] WAVE_SAW    = 2'b01;
    localparam logic [1:0] WAVE_TRI    = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [BITLEN-1:0] phase;
    logic [BITLEN-1:0] phase_nxt;
    logic [1:0]        act_wave;
    logic [1:0]        act_wave_nxt;
    logic [1:0]        act_atten;
    logic [1:0]        act_atten_nxt;
    logic [BITLEN-1:0] sample_q;
    logic [BITLEN-1:0] sample_nxt;
    logic              valid_q;
    logic              valid_nxt;
    logic              busy_q;

    logic              wrap;
    logic [BITLEN-1:0] tri_t;
    logic [BITLEN-1:0] raw;
    logic [BITLEN-1:0] emit;

    assign wrap  = (phase == MAX_VAL);
    assign tri_t = {phase[BITLEN-2:0], 1'b0};

    // Waveform lookup always uses the pre-increment phase and the latched selection.
    always_comb begin
        raw = MID_VAL;
        case (act_wave)
            WAVE_SQUARE: raw = phase[BITLEN-1] ? ZERO_VAL : MAX_VAL;
            WAVE_SAW:    raw = phase;
            WAVE_TRI:    raw = phase[BITLEN-1] ? ~tri_t : tri_t;
            default:     raw = MID_VAL;
        endcase
    end

    assign emit = raw >> act_atten;

    // RUN and DRAIN share step handling; en only decides where a period ends.
    always_comb begin
        state_nxt     = state;
        phase_nxt     = phase;
        act_wave_nxt  = act_wave;
        act_atten_nxt = act_atten;
        sample_nxt    = sample_q;
        valid_nxt     = 1'b0;

        case (state)
            IDLE: begin
                phase_nxt = ZERO_VAL;
                if (bus.en) begin
                    state_nxt     = RUN;
                    act_wave_nxt  = bus.wave_sel;
                    act_atten_nxt = bus.atten;
                end
            end

            RUN, DRAIN: begin
                if (bus.step) begin
                    sample_nxt = emit;
                    valid_nxt  = 1'b1;
                    phase_nxt  = phase + ONE_VAL;
                    if (wrap) begin
                        act_wave_nxt  = bus.wave_sel;
                        act_atten_nxt = bus.atten;
                    end
                end

                if (bus.step && wrap) begin
                    state_nxt = bus.en ? RUN : IDLE;
                end else begin
                    state_nxt = bus.en ? RUN : DRAIN;
                end
            end

            default: begin
                state_nxt = IDLE;
                phase_nxt = ZERO_VAL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            phase     <= ZERO_VAL;
            act_wave  <= 2'b00;
            act_atten <= 2'b00;
            sample_q  <= ZERO_VAL;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            phase     <= phase_nxt;
            act_wave  <= act_wave_nxt;
            act_atten <= act_atten_nxt;
            sample_q  <= sample_nxt;
            valid_q   <= valid_nxt;
            busy_q    <= (state_nxt != IDLE);
        end
    end

    assign bus.sample       = sample_q;
    assign bus.sample_valid = valid_q;
    assign bus.busy         = busy_q;
    assign bus.phase_out    = phase;

endmodule
`default_nettype wire

// File: tb/tb_wave_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_wave_gen
// Description : Directed self-checking bench for wave_gen (BITLEN = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wave_gen;

    localparam int BITLEN = 8;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;

    always #5 clk = ~clk;

    wave_gen_if #(.BITLEN(BITLEN)) bus ();

    wave_gen #(.BITLEN(BITLEN)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int checks = 0;
    int fails  = 0;
    int ph     = 0;
    int last   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One accepted step; gap idle cycles follow with no valid and a held sample.
    task automatic run_step(input int exp, input int gap);
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        ph   = (ph + 1) % 256;
        last = exp;
        check("step_valid", {31'd0, bus.sample_valid}, 32'd1);
        check("step_sample", {24'd0, bus.sample}, exp);
        check("step_phase", {24'd0, bus.phase_out}, ph);
        for (int g = 0; g < gap; g++) begin
            tick();
            check("gap_valid", {31'd0, bus.sample_valid}, 32'd0);
            check("gap_hold", {24'd0, bus.sample}, last);
        end
    endtask

    task automatic idle_step();
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        check("idle_valid", {31'd0, bus.sample_valid}, 32'd0);
        check("idle_hold", {24'd0, bus.sample}, last);
        check("idle_phase", {24'd0, bus.phase_out}, 32'd0);
        check("idle_busy", {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        bus.en       = 1'b0;
        bus.step     = 1'b0;
        bus.wave_sel = 2'b00;
        bus.atten    = 2'b00;
        #1;
        repeat (2) tick();

        check("rst_sample", {24'd0, bus.sample}, 32'd0);
        check("rst_valid", {31'd0, bus.sample_valid}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_phase", {24'd0, bus.phase_out}, 32'd0);

        n_rst = 1'b1;
        tick();
        idle_step();

        // Sawtooth, steps spaced 3 cycles apart
        bus.wave_sel = 2'b01;
        bus.en       = 1'b1;
        tick();
        check("en_busy", {31'd0, bus.busy}, 32'd1);
        check("en_phase", {24'd0, bus.phase_out}, 32'd0);
        for (int i = 0; i < 256; i++) run_step(i, 2);

        // Mid-period switch to square is deferred to the wrap
        for (int i = 0; i < 10; i++) run_step(i, 0);
        bus.wave_sel = 2'b00;
        for (int i = 10; i < 256; i++) run_step(i, 0);
        run_step(255, 0);
        bus.atten = 2'd2;
        for (int i = 1; i < 128; i++) run_step(255, 0);
        for (int i = 128; i < 256; i++) run_step(0, 0);

        // Square with atten 2, then triangle with atten 1 queued
        for (int i = 0; i < 128; i++) run_step(63, 0);
        bus.wave_sel = 2'b10;
        bus.atten    = 2'd1;
        for (int i = 128; i < 256; i++) run_step(0, 0);

        // Triangle with atten 1: 0,127,127,0 at phases 0,127,128,255
        run_step(0, 0);
        bus.wave_sel = 2'b11;
        bus.atten    = 2'd3;
        for (int p = 1; p < 256; p++) run_step((p < 128) ? p : (255 - p), 0);

        // Silence with atten 3: 128 >> 3
        run_step(16, 0);
        bus.wave_sel = 2'b01;
        bus.atten    = 2'd0;
        for (int i = 1; i < 256; i++) run_step(16, 0);

        // Drain from phase 100
        for (int i = 0; i < 100; i++) run_step(i, 0);
        bus.en = 1'b0;
        tick();
        check("drain_busy", {31'd0, bus.busy}, 32'd1);
        check("drain_phase", {24'd0, bus.phase_out}, 32'd100);
        for (int i = 100; i < 255; i++) run_step(i, 1);
        run_step(255, 0);
        tick();
        check("drain_end_busy", {31'd0, bus.busy}, 32'd0);
        idle_step();
        idle_step();

        // en with step from IDLE: step ignored
        bus.en   = 1'b1;
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        check("start_valid", {31'd0, bus.sample_valid}, 32'd0);
        check("start_busy", {31'd0, bus.busy}, 32'd1);
        check("start_phase", {24'd0, bus.phase_out}, 32'd0);

        // Steps every cycle; en dropped on the wrap step
        bus.step = 1'b1;
        for (int i = 0; i < 256; i++) begin
            if (i == 255) bus.en = 1'b0;
            tick();
            check("b2b_valid", {31'd0, bus.sample_valid}, 32'd1);
            check("b2b_sample", {24'd0, bus.sample}, i);
            check("b2b_phase", {24'd0, bus.phase_out}, (i + 1) % 256);
        end
        bus.step = 1'b0;
        ph   = 0;
        last = 255;
        tick();
        check("wrapoff_busy", {31'd0, bus.busy}, 32'd0);
        check("wrapoff_valid", {31'd0, bus.sample_valid}, 32'd0);
        idle_step();

        // DRAIN back to RUN without phase reset, then async reset at phase 37
        bus.en = 1'b1;
        tick();
        for (int i = 0; i < 30; i++) run_step(i, 0);
        bus.en = 1'b0;
        tick();
        run_step(30, 0);
        run_step(31, 0);
        bus.en = 1'b1;
        tick();
        check("resume_busy", {31'd0, bus.busy}, 32'd1);
        check("resume_phase", {24'd0, bus.phase_out}, 32'd32);
        for (int i = 32; i < 37; i++) run_step(i, 0);
        #2;
        n_rst = 1'b0;
        #1;
        check("arst_sample", {24'd0, bus.sample}, 32'd0);
        check("arst_valid", {31'd0, bus.sample_valid}, 32'd0);
        check("arst_busy", {31'd0, bus.busy}, 32'd0);
        check("arst_phase", {24'd0, bus.phase_out}, 32'd0);
        bus.en = 1'b0;
        ph     = 0;
        last   = 0;
        tick();
        n_rst = 1'b1;
        tick();
        idle_step();
        idle_step();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
